// File: rtl/key_debounce_if.sv
// Bundles the panel-side signals of key_debounce: sampling strobe and raw keys in,
// debounced level and press/release pulses out.
interface key_debounce_if #(
  parameter int NKEY = 4
);
  logic            tick_20ms;
  logic [NKEY-1:0] key_in;
  logic [NKEY-1:0] key_level;
  logic [NKEY-1:0] key_press;
  logic [NKEY-1:0] key_release;

  modport master (
    output tick_20ms,
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release
  );

  modport slave (
    input  tick_20ms,
    input  key_in,
    output key_level,
    output key_press,
    output key_release
  );
endinterface

// File: rtl/key_debounce.sv
// NKEY-wide active-low push-button debouncer sampled on the 20 ms divider strobe.
// Define KEY_AUTOREPEAT_EN to add timed auto-repeat press pulses while a key is held.
module key_debounce #(
  parameter int NKEY       = 4,
  parameter int DEB_TICKS  = 2,
  parameter int REP_DELAY  = 25,
  parameter int REP_PERIOD = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  key_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PCHK = 2'd1,
    HELD = 2'd2,
    RCHK = 2'd3
  } state_e;

  localparam logic [3:0] DEB4 = DEB_TICKS[3:0];

  generate
    if (DEB_TICKS < 1 || DEB_TICKS > 15 ||
        REP_DELAY < 1 || REP_DELAY > 63 ||
        REP_PERIOD < 1 || REP_PERIOD > 63) begin : g_bad_cfg
      $error("key_debounce: parameter out of range");
    end
  endgenerate

  logic [NKEY-1:0] key_meta_q;
  logic [NKEY-1:0] key_sync_q;
  logic            tick_meta_q;
  logic            tick_sync_q;
  logic            tick_dly_q;
  logic            tick_en;

  // The divider output is only a data signal here; its rising edge becomes a one-clk enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_meta_q  <= '1;
      key_sync_q  <= '1;
      tick_meta_q <= 1'b0;
      tick_sync_q <= 1'b0;
      tick_dly_q  <= 1'b0;
    end else begin
      key_meta_q  <= bus.key_in;
      key_sync_q  <= key_meta_q;
      tick_meta_q <= bus.tick_20ms;
      tick_sync_q <= tick_meta_q;
      tick_dly_q  <= tick_sync_q;
    end
  end

  assign tick_en = tick_sync_q & ~tick_dly_q;

  for (genvar gi = 0; gi < NKEY; gi++) begin : g_key
    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       p;
    logic       press_d;
    logic       release_d;
    logic       rep_fire;
    logic       level_q;
    logic       press_q;
    logic       release_q;

    assign p = ~key_sync_q[gi];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        cnt_q     <= 4'd0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= (state_d == HELD) || (state_d == RCHK);
        press_q   <= press_d | rep_fire;
        release_q <= release_d;
      end
    end

    // cnt holds the length of the current run of samples that disagree with the accepted level.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (tick_en) begin
        case (state_q)
          IDLE: begin
            if (p) begin
              if (DEB_TICKS == 1) begin
                state_d = HELD;
                press_d = 1'b1;
              end else begin
                state_d = PCHK;
                cnt_d   = 4'd1;
              end
            end
          end
          PCHK: begin
            if (p) begin
              if (cnt_q + 4'd1 == DEB4) begin
                state_d = HELD;
                cnt_d   = 4'd0;
                press_d = 1'b1;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end else begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end
          end
          HELD: begin
            if (!p) begin
              if (DEB_TICKS == 1) begin
                state_d   = IDLE;
                release_d = 1'b1;
              end else begin
                state_d = RCHK;
                cnt_d   = 4'd1;
              end
            end
          end
          RCHK: begin
            if (!p) begin
              if (cnt_q + 4'd1 == DEB4) begin
                state_d   = IDLE;
                cnt_d     = 4'd0;
                release_d = 1'b1;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end else begin
              state_d = HELD;
              cnt_d   = 4'd0;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        endcase
      end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [5:0] DLY6 = REP_DELAY[5:0];
    localparam logic [5:0] PER6 = REP_PERIOD[5:0];

    logic [5:0] rep_cnt_q, rep_cnt_d;
    logic       rep_phase_q, rep_phase_d;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rep_cnt_q   <= 6'd0;
        rep_phase_q <= 1'b0;
      end else begin
        rep_cnt_q   <= rep_cnt_d;
        rep_phase_q <= rep_phase_d;
      end
    end

    // Counts pressed samples taken in HELD; RCHK neither counts nor clears, so a short bounce only pauses it.
    always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      rep_fire    = 1'b0;
      if (state_q == IDLE || state_q == PCHK) begin
        rep_cnt_d   = 6'd0;
        rep_phase_d = 1'b0;
      end else if (tick_en && state_q == HELD && p) begin
        if (rep_cnt_q + 6'd1 == (rep_phase_q ? PER6 : DLY6)) begin
          rep_fire    = 1'b1;
          rep_cnt_d   = 6'd0;
          rep_phase_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 6'd1;
        end
      end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign bus.key_level[gi]   = level_q;
    assign bus.key_press[gi]   = press_q;
    assign bus.key_release[gi] = release_q;
  end

endmodule
